// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, error codes and the instruction word width.
package im_loader_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      WORD_HI,
      WORD_LO,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_SIZE = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;

endpackage

// File: rtl/im_loader.sv
// Boot-time loader: receives a framed, XOR-checksummed byte stream, writes big-endian
// 16-bit words to instruction memory and holds the CPU until a frame verifies.
module im_loader
   import im_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          DEPTH_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [15:0]          wr_addr,
   output logic [INSTR_W-1:0]   wr_data,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [15:0]          words_loaded
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

   state_t              r_state;
   state_t              w_next;
   logic [15:0]         r_cnt;
   logic [7:0]          r_hi;
   logic [7:0]          r_xor;
   logic [15:0]         r_words;
   logic                r_wr_en;
   logic [15:0]         r_wr_addr;
   logic [INSTR_W-1:0]  r_wr_data;
   logic                r_done;
   logic [1:0]          r_err_code;

   logic                w_in_ready;
   logic                w_accept;
   logic                w_start_frame;
   logic [15:0]         w_n;
   logic                w_oversize;
   logic                w_last_word;
   logic                w_chk_ok;

   assign w_in_ready    = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                          (r_state == WORD_HI) || (r_state == WORD_LO) ||
                          (r_state == CHK);
   assign w_accept      = in_valid & w_in_ready;
   assign w_start_frame = start & ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
   assign w_n           = {r_cnt[15:8], in_data};
   assign w_oversize    = ({1'b0, w_n} > DEPTH_L);
   assign w_last_word   = ((r_words + 16'd1) == r_cnt);
   assign w_chk_ok      = (in_data == r_xor);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = CNT_HI;
         CNT_HI:  if (w_accept) w_next = CNT_LO;
         CNT_LO: begin
            if (w_accept) begin
               if (w_oversize)       w_next = ERR;
               else if (w_n == '0)   w_next = CHK;
               else                  w_next = WORD_HI;
            end
         end
         WORD_HI: if (w_accept) w_next = WORD_LO;
         WORD_LO: if (w_accept) w_next = w_last_word ? CHK : WORD_HI;
         CHK:     if (w_accept) w_next = w_chk_ok ? DONE : ERR;
         DONE:    if (start) w_next = CNT_HI;
         ERR:     if (start) w_next = CNT_HI;
         default: w_next = IDLE;
      endcase
   end

   // Byte assembly, checksum accumulation and the registered write/done strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_hi       <= '0;
         r_xor      <= '0;
         r_words    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= BASE_ADDR;
         r_wr_data  <= '0;
         r_done     <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (w_start_frame) begin
            r_words    <= '0;
            r_xor      <= '0;
            r_err_code <= ERR_NONE;
         end
         if (w_accept) begin
            case (r_state)
               CNT_HI: begin
                  r_cnt[15:8] <= in_data;
                  r_xor       <= r_xor ^ in_data;
               end
               CNT_LO: begin
                  r_cnt[7:0] <= in_data;
                  r_xor      <= r_xor ^ in_data;
                  if (w_oversize) r_err_code <= ERR_SIZE;
               end
               WORD_HI: begin
                  r_hi  <= in_data;
                  r_xor <= r_xor ^ in_data;
               end
               WORD_LO: begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= {r_hi, in_data};
                  r_wr_addr <= BASE_ADDR + {r_words[14:0], 1'b0};
                  r_words   <= r_words + 16'd1;
                  r_xor     <= r_xor ^ in_data;
               end
               CHK: begin
                  if (w_chk_ok) r_done     <= 1'b1;
                  else          r_err_code <= ERR_CHK;
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign wr_en        = r_wr_en;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;
   assign cpu_hold     = (r_state != DONE);
   assign done         = r_done;
   assign err          = (r_state == ERR);
   assign err_code     = r_err_code;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame loads, checksum/size errors, stalls,
// mid-frame reset and a full-depth frame, with hand-computed expectations.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;

   int tests = 0;
   int fails = 0;

   logic [15:0] log_addr [0:511];
   logic [15:0] log_data [0:511];
   int          n_wr = 0;

   im_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .err_code     (err_code),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && wr_en) begin
         if (n_wr < 512) begin
            log_addr[n_wr] <= wr_addr;
            log_data[n_wr] <= wr_data;
         end
         n_wr <= n_wr + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Presents one byte after `gap` idle cycles; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $error("FAIL send_ready: observed in_ready 0 expected 1 for byte %h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_cpu_hold", cpu_hold, 1'b1);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_words", words_loaded, 16'h0000);
      check("rst_err", err, 1'b0);
      check("rst_err_code", err_code, 2'd0);
      check("rst_wr_addr", wr_addr, 16'h0000);
      check("rst_done", done, 1'b0);

      // One-word frame, in_valid continuous; xor 00^01^12^34 = 27
      pulse_start();
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      check("f1_wr_en", wr_en, 1'b1);
      check("f1_wr_addr", wr_addr, 16'h0000);
      check("f1_wr_data", wr_data, 16'h1234);
      check("f1_hold_before_chk", cpu_hold, 1'b1);
      send(8'h27, 0);
      check("f1_done", done, 1'b1);
      check("f1_cpu_hold", cpu_hold, 1'b0);
      check("f1_words", words_loaded, 16'd1);
      @(posedge clk);
      #1;
      check("f1_done_pulse", done, 1'b0);
      check("f1_cpu_hold_stays", cpu_hold, 1'b0);
      check("f1_nwr", 16'(n_wr), 16'd1);

      // Two-word frame with random gaps; xor 00^02^AA^BB^CC^DD = 02
      pulse_start();
      check("f2_hold_raised", cpu_hold, 1'b1);
      send(8'h00, $urandom_range(0, 3));
      send(8'h02, $urandom_range(0, 3));
      send(8'hAA, $urandom_range(0, 3));
      send(8'hBB, $urandom_range(0, 3));
      send(8'hCC, $urandom_range(0, 3));
      send(8'hDD, $urandom_range(0, 3));
      send(8'h02, $urandom_range(0, 3));
      check("f2_done", done, 1'b1);
      check("f2_cpu_hold", cpu_hold, 1'b0);
      check("f2_words", words_loaded, 16'd2);
      @(negedge clk);
      check("f2_nwr", 16'(n_wr), 16'd3);
      check("f2_w0_addr", log_addr[1], 16'h0000);
      check("f2_w0_data", log_data[1], 16'hAABB);
      check("f2_w1_addr", log_addr[2], 16'h0002);
      check("f2_w1_data", log_data[2], 16'hCCDD);

      // Bad checksum 26 (correct is 27)
      pulse_start();
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      send(8'h26, 0);
      check("f3_err", err, 1'b1);
      check("f3_err_code", err_code, 2'd2);
      check("f3_cpu_hold", cpu_hold, 1'b1);
      check("f3_done", done, 1'b0);
      check("f3_in_ready", in_ready, 1'b0);
      @(negedge clk);
      check("f3_nwr", 16'(n_wr), 16'd4);
      check("f3_w_addr", log_addr[3], 16'h0000);
      check("f3_w_data", log_data[3], 16'h1234);
      pulse_start();
      check("f3_err_cleared", err, 1'b0);
      check("f3_code_cleared", err_code, 2'd0);
      check("f3_words_cleared", words_loaded, 16'd0);
      check("f3_ready_cnt_hi", in_ready, 1'b1);

      // Oversize count N = 257, continuing the frame just started
      send(8'h01, 0);
      send(8'h01, 0);
      check("f4_err", err, 1'b1);
      check("f4_err_code", err_code, 2'd1);
      check("f4_in_ready", in_ready, 1'b0);
      check("f4_cpu_hold", cpu_hold, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("f4_no_write", 16'(n_wr), 16'd4);
      check("f4_still_err", err_code, 2'd1);

      // Empty frame; a start inside the frame must be ignored
      pulse_start();
      send(8'h00, 0);
      pulse_start();
      send(8'h00, 0);
      send(8'h00, 0);
      check("f5_done", done, 1'b1);
      check("f5_cpu_hold", cpu_hold, 1'b0);
      check("f5_words", words_loaded, 16'd0);
      check("f5_err", err, 1'b0);
      @(negedge clk);
      check("f5_nwr", 16'(n_wr), 16'd4);

      // Reset after the second word's high byte of a 2-word frame
      pulse_start();
      check("f6_hold_raised", cpu_hold, 1'b1);
      send(8'h00, 0);
      send(8'h02, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      send(8'h33, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("f6_cpu_hold", cpu_hold, 1'b1);
      check("f6_in_ready", in_ready, 1'b0);
      check("f6_words", words_loaded, 16'd0);
      check("f6_err", err, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h44;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("f6_nwr", 16'(n_wr), 16'd5);
      check("f6_w_data", log_data[4], 16'h1122);
      check("f6_still_idle", in_ready, 1'b0);

      // Full-depth frame N = 256, word i = {i, ~i}; each word xors to FF, so chk = 01^00 = 01
      pulse_start();
      send(8'h01, 0);
      send(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] bi;
         bi = i[7:0];
         send(bi, 0);
         send(~bi, 0);
      end
      send(8'h01, 0);
      check("f7_done", done, 1'b1);
      check("f7_cpu_hold", cpu_hold, 1'b0);
      check("f7_words", words_loaded, 16'h0100);
      check("f7_err", err, 1'b0);
      @(negedge clk);
      check("f7_nwr", 16'(n_wr), 16'd261);
      check("f7_first_addr", log_addr[5], 16'h0000);
      check("f7_first_data", log_data[5], 16'h00FF);
      check("f7_last_addr", log_addr[260], 16'h01FE);
      check("f7_last_data", log_data[260], 16'hFF00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
